cpu_sequencer: RTL and testbench

- T-state sequencer for the 8-bit accumulator CPU.
- Decodes the 4-bit opcode from the instruction register, plus the ALU carry and zero flags, into the 15-bit control word.
- The control word drives the PC, MAR/RAM, IR, accumulator, ALU, B and output registers.
- Supports free-run and single-step execution and a terminal halt state.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_microcode_decode.sv | 90 +++++++++
 rtl/cpu_sequencer.sv | 92 +++++++++
 tb/tb_cpu_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU sequencer: opcodes, T-state codes,
// control-word bit positions and the idle control word.
package cpu_pkg;

  localparam int CW_W = 15;
  typedef logic [CW_W-1:0] cw_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] T0     = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] T3     = 3'd3;
  localparam logic [2:0] T4     = 3'd4;
  localparam logic [2:0] T5     = 3'd5;
  localparam logic [2:0] T_HALT = 3'd7;

  localparam int CS_CP   = 14;
  localparam int CS_EP   = 13;
  localparam int CS_LP   = 12;
  localparam int CS_NLMA = 11;
  localparam int CS_NLMD = 10;
  localparam int CS_NCE  = 9;
  localparam int CS_NLR  = 8;
  localparam int CS_NLI  = 7;
  localparam int CS_NEI  = 6;
  localparam int CS_NLA  = 5;
  localparam int CS_EA   = 4;
  localparam int CS_SUB  = 3;
  localparam int CS_EU   = 2;
  localparam int CS_NLB  = 1;
  localparam int CS_NLO  = 0;

  // Active-low strobes high, active-high strobes low.
  localparam cw_t CW_IDLE = 15'h0FE3;

  // Memory-operand instructions run the full T3..T5 execute phase.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/cpu_microcode_decode.sv
// Combinational microcode ROM: (T-state, opcode, flags) -> control word.
module cpu_microcode_decode
  import cpu_pkg::*;
(
  input  logic [2:0] t_state,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output cw_t        cw
);

  always_comb begin
    cw = CW_IDLE;
    case (t_state)
      T0: begin
        cw[CS_EP]   = 1'b1;
        cw[CS_NLMA] = 1'b0;
      end
      T1: cw[CS_CP] = 1'b1;
      T2: begin
        cw[CS_NCE] = 1'b0;
        cw[CS_NLI] = 1'b0;
      end
      T3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CS_NEI]  = 1'b0;
            cw[CS_NLMA] = 1'b0;
          end
          OP_LDI: begin
            cw[CS_NEI] = 1'b0;
            cw[CS_NLA] = 1'b0;
          end
          OP_JMP: begin
            cw[CS_NEI] = 1'b0;
            cw[CS_LP]  = 1'b1;
          end
          // Conditional jumps always drive the operand; only the PC load is gated.
          OP_JC: begin
            cw[CS_NEI] = 1'b0;
            cw[CS_LP]  = cf;
          end
          OP_JZ: begin
            cw[CS_NEI] = 1'b0;
            cw[CS_LP]  = zf;
          end
          OP_OUT: begin
            cw[CS_EA]  = 1'b1;
            cw[CS_NLO] = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            cw[CS_NCE] = 1'b0;
            cw[CS_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cw[CS_NCE] = 1'b0;
            cw[CS_NLB] = 1'b0;
          end
          OP_STA: begin
            cw[CS_EA]   = 1'b1;
            cw[CS_NLMD] = 1'b0;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_ADD: begin
            cw[CS_EU]  = 1'b1;
            cw[CS_NLA] = 1'b0;
          end
          OP_SUB: begin
            cw[CS_EU]  = 1'b1;
            cw[CS_NLA] = 1'b0;
            cw[CS_SUB] = 1'b1;
          end
          OP_STA: cw[CS_NLR] = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// T-state sequencer: owns the state register, step edge detection and the
// advance gating that forces the idle word on non-advancing cycles.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int STEP_SYNC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic [3:0]    opcode,
  input  logic          cf,
  input  logic          zf,
  output logic [14:0]   control_signals,
  output logic [2:0]    t_state,
  output logic          halted
);

  logic [2:0] state_q, state_d;
  logic       step_s;
  logic       step_prev_q, step_prev_d;
  logic       step_rise;
  logic       adv;
  cw_t        dec_cw;

  generate
    if (STEP_SYNC != 0) begin : g_sync
      logic [1:0] sync_q, sync_d;
      always_comb sync_d = {sync_q[0], step};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
      end
      assign step_s = sync_q[1];
    end else begin : g_nosync
      assign step_s = step;
    end
  endgenerate

  always_comb begin
    step_prev_d = step_s;
    step_rise   = step_s & ~step_prev_q;
    adv         = run | step_rise;
  end

  always_comb begin
    state_d = state_q;
    if (adv && state_q != T_HALT) begin
      case (state_q)
        T0: state_d = T1;
        T1: state_d = T2;
        T2: state_d = T3;
        T3: begin
          if (is_mem_op(opcode))    state_d = T4;
          else if (opcode == OP_HLT) state_d = T_HALT;
          else                       state_d = T0;
        end
        T4: state_d = T5;
        default: state_d = T0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= T0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_prev_q <= step_prev_d;
    end
  end

  cpu_microcode_decode u_decode (
    .t_state (state_q),
    .opcode  (opcode),
    .cf      (cf),
    .zf      (zf),
    .cw      (dec_cw)
  );

  // rst gates the word directly so reset is visible in the same cycle it rises.
  always_comb begin
    control_signals = CW_IDLE;
    if (!rst && adv && state_q != T_HALT) control_signals = dec_cw;
  end

  assign t_state = state_q;
  assign halted  = (state_q == T_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed instruction walks plus a
// randomized run checked against a cycle-level behavioural model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, step, cf, zf;
  logic [3:0]  opcode;
  logic [14:0] control_signals;
  logic [2:0]  t_state;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: T-state number (7 = halted) and step history for the 2-flop sync.
  int m_st;
  bit h1, h2, h3;

  localparam logic [14:0] IDLE = 15'h0FE3;

  cpu_sequencer #(.STEP_SYNC(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .step            (step),
    .opcode          (opcode),
    .cf              (cf),
    .zf              (zf),
    .control_signals (control_signals),
    .t_state         (t_state),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ref_word(int st, logic [3:0] op, logic c, logic z);
    logic [14:0] w;
    bit mem;
    w = IDLE;
    mem = (op <= 4'h3);
    case (st)
      0: begin w[13] = 1'b1; w[11] = 1'b0; end
      1: w[14] = 1'b1;
      2: begin w[9] = 1'b0; w[7] = 1'b0; end
      3: begin
        if (mem)          begin w[6] = 1'b0; w[11] = 1'b0; end
        else if (op == 4) begin w[6] = 1'b0; w[5] = 1'b0; end
        else if (op == 5) begin w[6] = 1'b0; w[12] = 1'b1; end
        else if (op == 6) begin w[6] = 1'b0; w[12] = c; end
        else if (op == 7) begin w[6] = 1'b0; w[12] = z; end
        else if (op == 14) begin w[4] = 1'b1; w[0] = 1'b0; end
      end
      4: begin
        if (op == 0)                begin w[9] = 1'b0; w[5] = 1'b0; end
        else if (op == 1 || op == 2) begin w[9] = 1'b0; w[1] = 1'b0; end
        else if (op == 3)           begin w[4] = 1'b1; w[10] = 1'b0; end
      end
      5: begin
        if (op == 1 || op == 2) begin w[2] = 1'b1; w[5] = 1'b0; if (op == 2) w[3] = 1'b1; end
        else if (op == 3)       w[8] = 1'b0;
      end
      default: ;
    endcase
    return w;
  endfunction

  function automatic int ref_next(int st, logic [3:0] op);
    if (st == 7) return 7;
    if (st == 3) return (op <= 4'h3) ? 4 : ((op == 4'hF) ? 7 : 0);
    if (st == 5) return 0;
    return st + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then clock once and advance the model.
  task automatic tick(input string tag);
    bit rise, adv;
    logic [14:0] exp;
    #1;
    rise = h2 & ~h3;
    adv  = run | rise;
    exp  = (m_st == 7 || !adv) ? IDLE : ref_word(m_st, opcode, cf, zf);
    chk({tag, ":cw"}, {17'd0, control_signals}, {17'd0, exp});
    chk({tag, ":ts"}, {29'd0, t_state}, m_st);
    chk({tag, ":halt"}, {31'd0, halted}, {31'd0, (m_st == 7)});
    @(posedge clk);
    if (adv && m_st != 7) m_st = ref_next(m_st, opcode);
    h3 = h2; h2 = h1; h1 = step;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst:cw", {17'd0, control_signals}, {17'd0, IDLE});
    chk("rst:ts", {29'd0, t_state}, 32'd0);
    chk("rst:halt", {31'd0, halted}, 32'd0);
    m_st = 0; h1 = 0; h2 = 0; h3 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [14:0] lda_words [6];
  int adv_cnt, cp_cnt, prev_ts, halt_age;

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    m_st = 0; h1 = 0; h2 = 0; h3 = 0;
    #2;
    do_reset();

    // LDA walk with literal control words.
    lda_words = '{15'h27E3, 15'h4FE3, 15'h0D63, 15'h07A3, 15'h0DC3, 15'h0FE3};
    run = 1'b1; opcode = 4'h0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("lda_t%0d", i), {17'd0, control_signals}, {17'd0, lda_words[i]});
      tick("lda");
    end
    #1; chk("lda_wrap", {29'd0, t_state}, 32'd0);

    // ADD then SUB: T4/T5 words.
    opcode = 4'h1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 4) chk("add_t4", {17'd0, control_signals}, 32'h0DE1);
      if (i == 5) chk("add_t5", {17'd0, control_signals}, 32'h0FC7);
      tick("add");
    end
    opcode = 4'h2;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 5) chk("sub_t5", {17'd0, control_signals}, 32'h0FCF);
      tick("sub");
    end

    // Conditional jumps, taken and not taken, 4-cycle length.
    for (int j = 0; j < 4; j++) begin
      opcode = (j < 2) ? 4'h6 : 4'h7;
      cf = (j == 1); zf = (j == 3);
      for (int i = 0; i < 4; i++) begin
        #1;
        if (i == 3) chk($sformatf("jcz%0d_t3", j), {17'd0, control_signals},
                        (j == 1 || j == 3) ? 32'h1FA3 : 32'h0FA3);
        tick("jcz");
      end
      #1; chk($sformatf("jcz%0d_next", j), {29'd0, t_state}, 32'd0);
    end

    // Asynchronous reset in the middle of ADD T4.
    opcode = 4'h1;
    for (int i = 0; i < 4; i++) tick("pre_rst");
    #1; chk("mid_t4_ts", {29'd0, t_state}, 32'd4);
    do_reset();
    #1; chk("post_rst_t0", {17'd0, control_signals}, 32'h27E3);
    tick("post_rst");

    // Single step: held step gives one advance and one Cp pulse.
    run = 1'b0;
    for (int i = 0; i < 3; i++) tick("step_idle");
    step = 1'b1;
    adv_cnt = 0; cp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      prev_ts = t_state;
      if (control_signals[14]) cp_cnt++;
      tick("step_hold");
      if (t_state != prev_ts) adv_cnt++;
    end
    chk("step_adv", adv_cnt, 32'd1);
    chk("step_cp", cp_cnt, 32'd1);
    step = 1'b0;
    for (int i = 0; i < 3; i++) tick("step_rel");

    // Halt: finish current instruction, then HLT, then stays halted.
    run = 1'b1;
    while (m_st != 0) tick("to_t0");
    opcode = 4'hF;
    for (int i = 0; i < 4; i++) tick("hlt");
    for (int i = 0; i < 8; i++) begin
      run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      tick("halted");
    end
    #1;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_ts", {29'd0, t_state}, 32'd7);
    do_reset();

    // Randomized run against the model.
    halt_age = 0;
    for (int n = 0; n < 800; n++) begin
      if (m_st <= 2) begin
        opcode = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        cf = 1'($urandom_range(0, 1));
        zf = 1'($urandom_range(0, 1));
      end
      run  = ($urandom_range(0, 3) != 0);
      step = 1'($urandom_range(0, 1));
      if (m_st == 7) halt_age++;
      if (halt_age > 4 || $urandom_range(0, 99) == 0) begin
        halt_age = 0;
        do_reset();
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
